// File: rtl/jk_cmd_sequencer.sv
// jk_cmd_sequencer: buffers {j,k} commands with repeat counts in a small FIFO
// and plays each one onto registered j/k outputs for rpt+1 cycles, back to back.
// q_model tracks the downstream JK flop's q cycle for cycle.
`timescale 1ns/1ps
module jk_cmd_sequencer #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 4
) (
    input  logic                     clk,
    input  logic                     clear,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [1:0]               cmd_op,
    input  logic [CNT_W-1:0]         cmd_rpt,
    output logic                     j,
    output logic                     k,
    output logic                     done,
    output logic                     busy,
    output logic                     q_model,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0]   FULL_CNT = DEPTH[PTR_W:0];
    localparam logic [PTR_W:0]   CNT_ONE  = 1;
    localparam logic [PTR_W-1:0] PTR_ONE  = 1;
    localparam logic [CNT_W-1:0] REM_ONE  = 1;

    typedef enum logic {IDLE, ISSUE} state_t;

    typedef struct packed {
        logic [1:0]       op;
        logic [CNT_W-1:0] rpt;
    } cmd_t;

    cmd_t             mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;

    state_t           state_q;
    logic [CNT_W-1:0] rem_q;
    logic             j_q, k_q, qm_q;

    logic             push, pop, last;
    cmd_t             head;

    // Handshake and sequencing decisions shared by the FIFO and the FSM.
    assign cmd_ready = (count_q < FULL_CNT);
    assign push      = cmd_valid & cmd_ready;
    assign last      = (state_q == ISSUE) && (rem_q == '0);
    assign pop       = (count_q != '0) && ((state_q == IDLE) || last);
    assign head      = mem_q[rd_ptr_q];

    // Storage array: written on accepted pushes only.
    // NOTE: the data array has no reset; validity is tracked by count_q, so clearing it buys nothing.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= cmd_t'({cmd_op, cmd_rpt});
        end
    end

    // Next-state logic for pointers and occupancy; pointers wrap modulo DEPTH.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // FIFO pointer and occupancy registers.
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Issue FSM with registered j/k, plus the downstream flop's q tracked from the current j/k.
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state_q <= IDLE;
            rem_q   <= '0;
            j_q     <= 1'b0;
            k_q     <= 1'b0;
            qm_q    <= 1'b0;
        end else begin
            case ({j_q, k_q})
                2'b01:   qm_q <= 1'b0;
                2'b10:   qm_q <= 1'b1;
                2'b11:   qm_q <= ~qm_q;
                default: qm_q <= qm_q;
            endcase

            case (state_q)
                IDLE: begin
                    if (pop) begin
                        {j_q, k_q} <= head.op;
                        rem_q      <= head.rpt;
                        state_q    <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (rem_q != '0) begin
                        rem_q <= rem_q - REM_ONE;
                    end else if (pop) begin
                        {j_q, k_q} <= head.op;
                        rem_q      <= head.rpt;
                    end else begin
                        j_q     <= 1'b0;
                        k_q     <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign j       = j_q;
    assign k       = k_q;
    assign done    = last;
    assign busy    = (state_q == ISSUE) || (count_q != '0);
    assign q_model = qm_q;
    assign count   = count_q;

endmodule

// File: tb/tb_jk_cmd_sequencer.sv
// Self-checking bench for jk_cmd_sequencer: a queue-based command model plus a
// downstream JK flop fed by the DUT's j/k on the same clk/clear.
`timescale 1ns/1ps
module tb_jk_cmd_sequencer;

    localparam int DEPTH = 4;
    localparam int CNT_W = 4;

    logic       clk;
    logic       clear;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [3:0] cmd_rpt;
    logic       j, k, done, busy, q_model;
    logic [2:0] count;
    logic       ds_q;

    int n_cmp = 0;
    int n_err = 0;

    jk_cmd_sequencer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .clear     (clear),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_rpt   (cmd_rpt),
        .j         (j),
        .k         (k),
        .done      (done),
        .busy      (busy),
        .q_model   (q_model),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Downstream JK flop on the same clock and clear as the DUT.
    always @(posedge clk or posedge clear) begin
        if (clear) ds_q <= 1'b0;
        else begin
            case ({j, k})
                2'b01:   ds_q <= 1'b0;
                2'b10:   ds_q <= 1'b1;
                2'b11:   ds_q <= ~ds_q;
                default: ds_q <= ds_q;
            endcase
        end
    end

    // Observed outputs packed: {ready, j, k, done, busy, q_model, count, downstream q}
    logic [9:0] act;
    assign act = {cmd_ready, j, k, done, busy, q_model, count, ds_q};

    // ---------------- reference model ----------------
    typedef struct {
        logic [1:0] op;
        logic [3:0] rpt;
    } cmd_t;

    cmd_t       mq[$];      // accepted, not yet started commands
    int         cur_left;   // cycles left of the command on j/k, including this one (0 = idle)
    logic [1:0] cur_op;
    logic       m_q;

    function automatic logic jk_next(input logic q, input logic [1:0] op);
        case (op)
            2'b01:   return 1'b0;
            2'b10:   return 1'b1;
            2'b11:   return ~q;
            default: return q;
        endcase
    endfunction

    function automatic logic [9:0] exp_vec();
        logic [1:0] o;
        o = (cur_left > 0) ? cur_op : 2'b00;
        return {mq.size() < DEPTH, o, cur_left == 1, (cur_left > 0) || (mq.size() > 0),
                m_q, 3'(mq.size()), m_q};
    endfunction

    task automatic model_reset();
        mq.delete();
        cur_left = 0;
        cur_op   = 2'b00;
        m_q      = 1'b0;
    endtask

    // One clock: drive inputs, advance the model across the edge, settle 1ns past the edge.
    task automatic step(input logic v, input logic [1:0] op, input logic [3:0] rpt);
        bit   push_ok, pop_ok;
        cmd_t c;
        cmd_valid = v;
        cmd_op    = op;
        cmd_rpt   = rpt;
        push_ok   = v && (mq.size() < DEPTH);
        pop_ok    = (cur_left <= 1) && (mq.size() > 0);
        @(posedge clk);
        if (cur_left > 0) m_q = jk_next(m_q, cur_op);
        if (pop_ok) begin
            c        = mq.pop_front();
            cur_op   = c.op;
            cur_left = int'(c.rpt) + 1;
        end else if (cur_left > 0) begin
            cur_left--;
        end
        if (push_ok) begin
            c.op  = op;
            c.rpt = rpt;
            mq.push_back(c);
        end
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        #2;
        clear = 1'b0;
        model_reset();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        clear     = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_rpt   = 4'd0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (act !== 10'b1_00_0_0_0_000_0) begin
            n_err++;
            $display("FAIL reset_state: got %b want %b", act, 10'b1_00_0_0_0_000_0);
        end
        clear = 1'b0;
        model_reset();
    endtask

    task automatic test_single();
        logic [3:0] lit [5];
        lit = '{4'b0000, 4'b1000, 4'b1001, 4'b1011, 4'b0001};   // {j,k,done,q} after edges N..N+4
        do_clear();
        for (int i = 0; i < 5; i++) begin
            if (i == 0) step(1'b1, 2'b10, 4'd2);
            else        step(1'b0, 2'b00, 4'd0);
            n_cmp++;
            if ({j, k, done, q_model} !== lit[i]) begin
                n_err++;
                $display("FAIL single_cmd edge N+%0d: got jkdq=%b want %b", i, {j, k, done, q_model}, lit[i]);
            end
            n_cmp++;
            if (act !== exp_vec()) begin
                n_err++;
                $display("FAIL single_model edge N+%0d: got %b want %b", i, act, exp_vec());
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] lit [6];
        logic [1:0] ops [3];
        logic [3:0] rpts [3];
        lit  = '{4'b0000, 4'b1110, 4'b1101, 4'b1110, 4'b0111, 4'b0000};
        ops  = '{2'b11, 2'b11, 2'b01};
        rpts = '{4'd0, 4'd1, 4'd0};
        do_clear();
        for (int i = 0; i < 6; i++) begin
            if (i < 3) step(1'b1, ops[i], rpts[i]);
            else       step(1'b0, 2'b00, 4'd0);
            n_cmp++;
            if ({j, k, done, q_model} !== lit[i]) begin
                n_err++;
                $display("FAIL back_to_back edge N+%0d: got jkdq=%b want %b", i, {j, k, done, q_model}, lit[i]);
            end
            n_cmp++;
            if (act !== exp_vec()) begin
                n_err++;
                $display("FAIL b2b_model edge N+%0d: got %b want %b", i, act, exp_vec());
            end
        end
    endtask

    task automatic test_full();
        int  guard;
        do_clear();
        step(1'b1, 2'b10, 4'd15);                      // long command to stall the FSM
        guard = 0;
        while (mq.size() < DEPTH && guard < 10) begin
            step(1'b1, 2'($urandom_range(0, 3)), 4'd15);
            guard++;
            n_cmp++;
            if (act !== exp_vec()) begin
                n_err++;
                $display("FAIL full_fill step %0d: got %b want %b", guard, act, exp_vec());
            end
        end
        n_cmp++;
        if (cmd_ready !== 1'b0 || count !== 3'd4) begin
            n_err++;
            $display("FAIL full_flags: got ready=%b count=%0d want ready=0 count=4", cmd_ready, count);
        end
        step(1'b1, 2'b11, 4'd3);                       // 5th push must be refused
        n_cmp++;
        if (count !== 3'd4 || act !== exp_vec()) begin
            n_err++;
            $display("FAIL full_reject: got %b want %b", act, exp_vec());
        end
        guard = 0;
        while (mq.size() == DEPTH && guard < 40) begin
            step(1'b0, 2'b00, 4'd0);
            guard++;
            n_cmp++;
            if (act !== exp_vec()) begin
                n_err++;
                $display("FAIL full_wait step %0d: got %b want %b", guard, act, exp_vec());
            end
        end
        n_cmp++;
        if (cmd_ready !== 1'b1 || guard >= 40) begin
            n_err++;
            $display("FAIL full_after_pop: got ready=%b (waited %0d) want ready=1", cmd_ready, guard);
        end
        guard = 0;
        while ((cur_left > 0 || mq.size() > 0) && guard < 100) begin
            step(1'b0, 2'b00, 4'd0);
            guard++;
            n_cmp++;
            if (act !== exp_vec()) begin
                n_err++;
                $display("FAIL full_drain step %0d: got %b want %b", guard, act, exp_vec());
            end
        end
    endtask

    task automatic test_wrap();
        do_clear();
        step(1'b1, 2'b10, 4'd3);
        step(1'b1, 2'b01, 4'd0);
        step(1'b1, 2'b11, 4'd0);
        step(1'b0, 2'b00, 4'd0);
        step(1'b0, 2'b00, 4'd0);
        n_cmp++;
        if (act !== exp_vec()) begin
            n_err++;
            $display("FAIL wrap_setup: got %b want %b", act, exp_vec());
        end
        for (int i = 0; i < 7; i++) begin
            step(1'b1, 2'($urandom_range(0, 3)), 4'd0);  // push and pop on the same edge
            n_cmp++;
            if (count !== 3'd2) begin
                n_err++;
                $display("FAIL wrap_count step %0d: got %0d want 2", i, count);
            end
            n_cmp++;
            if (act !== exp_vec()) begin
                n_err++;
                $display("FAIL wrap_order step %0d: got %b want %b", i, act, exp_vec());
            end
        end
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 2'b00, 4'd0);
            n_cmp++;
            if (act !== exp_vec()) begin
                n_err++;
                $display("FAIL wrap_drain step %0d: got %b want %b", i, act, exp_vec());
            end
        end
    endtask

    task automatic test_clear_mid();
        do_clear();
        step(1'b1, 2'b10, 4'd9);
        step(1'b1, 2'b11, 4'd5);
        step(1'b1, 2'b01, 4'd2);
        step(1'b0, 2'b00, 4'd0);
        n_cmp++;
        if (act !== exp_vec() || busy !== 1'b1) begin
            n_err++;
            $display("FAIL clear_mid_pre: got %b want %b", act, exp_vec());
        end
        clear = 1'b1;
        #1;
        n_cmp++;
        if (act !== 10'b1_00_0_0_0_000_0) begin
            n_err++;
            $display("FAIL clear_mid_async: got %b want %b", act, 10'b1_00_0_0_0_000_0);
        end
        #1;
        clear = 1'b0;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 2'b00, 4'd0);
            n_cmp++;
            if (act !== exp_vec()) begin
                n_err++;
                $display("FAIL clear_mid_after step %0d: got %b want %b", i, act, exp_vec());
            end
        end
    endtask

    task automatic test_random();
        logic       v;
        logic [1:0] op;
        logic [3:0] rpt;
        do_clear();
        for (int i = 0; i < 400; i++) begin
            v   = 1'($urandom_range(0, 1));
            op  = 2'($urandom_range(0, 3));
            rpt = ($urandom_range(0, 7) == 0) ? 4'd15 : 4'($urandom_range(0, 2));
            step(v, op, rpt);
            n_cmp++;
            if (act !== exp_vec()) begin
                n_err++;
                $display("FAIL random step %0d: got %b want %b", i, act, exp_vec());
            end
        end
        for (int i = 0; i < 100 && (cur_left > 0 || mq.size() > 0); i++) begin
            step(1'b0, 2'b00, 4'd0);
            n_cmp++;
            if (act !== exp_vec()) begin
                n_err++;
                $display("FAIL random_drain step %0d: got %b want %b", i, act, exp_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_full();
        test_wrap();
        test_clear_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
